// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared types and button codes for the movement command path
//
// Purpose: executor FSM states, button code constants and the decoded
// direction type used by the decoder and the executor.
// Ports: none (package).

package input_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_APPLY
  } state_t;

  localparam logic [3:0] BTN_UP    = 4'b0001;
  localparam logic [3:0] BTN_DOWN  = 4'b0010;
  localparam logic [3:0] BTN_LEFT  = 4'b0100;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT,
    DIR_ILLEGAL
  } dir_t;

endpackage

// File: rtl/input_cmd_decode.sv
// rtl/input_cmd_decode.sv - combinational button code to direction decoder
//
// Purpose: map a 4-bit one-hot button code onto a movement direction.
// All-zero means "no event"; any multi-hot code is illegal.
// Ports:
//   code  in  4  raw button code from the event FIFO
//   dir   out    decoded direction (dir_t)

module input_cmd_decode
  import input_pkg::*;
(
  input  logic [3:0] code,
  output dir_t       dir
);

  always_comb begin
    dir = DIR_ILLEGAL;
    case (code)
      4'b0000:   dir = DIR_NONE;
      BTN_UP:    dir = DIR_UP;
      BTN_DOWN:  dir = DIR_DOWN;
      BTN_LEFT:  dir = DIR_LEFT;
      BTN_RIGHT: dir = DIR_RIGHT;
      default:   dir = DIR_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/input_cmd_executor.sv
// rtl/input_cmd_executor.sv - per-frame button command executor with clamped sprite position
//
// Purpose: once per frame tick, pop one button code from the input FIFO,
// decode it and update a clamped (x,y) position; count illegal codes.
// Ports:
//   sys_clock   in   1      system clock (rising edge)
//   reset_n     in   1      asynchronous active-low reset
//   enable      in   1      allow new fetches (an in-flight fetch always completes)
//   frame_tick  in   1      one pulse per video frame
//   fifo_data   in   4      button code presented by the FIFO after a pop
//   fifo_rd_en  out  1      single-cycle pop request
//   pos_x/pos_y out  POS_W  current sprite position
//   move_pulse  out  1      one-cycle pulse when the position changed
//   err_cnt     out  ERR_W  saturating count of multi-hot codes

module input_cmd_executor
  import input_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int STEP   = 4,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int ERR_W  = 8
) (
  input  logic             sys_clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             frame_tick,
  input  logic [3:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             move_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  // One extra bit so a subtraction below zero shows up in the MSB and an
  // addition past the bound cannot wrap before the compare.
  localparam int              PW1    = POS_W + 1;
  localparam logic [POS_W:0]  STEP_E = PW1'(STEP);
  localparam logic [POS_W:0]  XMAX_E = PW1'(X_MAX);
  localparam logic [POS_W:0]  YMAX_E = PW1'(Y_MAX);

  state_t           state_q, state_d;
  logic             tick_pending_q, tick_pending_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic [POS_W-1:0] pos_y_q, pos_y_d;
  logic             move_pulse_q, move_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  dir_t             dir;

  logic [POS_W:0]   x_sub, x_add, y_sub, y_add;
  logic [POS_W-1:0] x_dn, x_up, y_dn, y_up;

  input_cmd_decode u_decode (
    .code (fifo_data),
    .dir  (dir)
  );

  // State register
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick_pending_q && enable) state_d = S_POP;
      S_POP:   state_d = S_WAIT;
      S_WAIT:  state_d = S_APPLY;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    fifo_rd_en = (state_q == S_POP);
  end

  // Clamped step candidates
  assign x_sub = {1'b0, pos_x_q} - STEP_E;
  assign x_add = {1'b0, pos_x_q} + STEP_E;
  assign y_sub = {1'b0, pos_y_q} - STEP_E;
  assign y_add = {1'b0, pos_y_q} + STEP_E;
  assign x_dn  = x_sub[POS_W] ? '0 : x_sub[POS_W-1:0];
  assign y_dn  = y_sub[POS_W] ? '0 : y_sub[POS_W-1:0];
  assign x_up  = (x_add > XMAX_E) ? XMAX_E[POS_W-1:0] : x_add[POS_W-1:0];
  assign y_up  = (y_add > YMAX_E) ? YMAX_E[POS_W-1:0] : y_add[POS_W-1:0];

  always_comb begin
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    err_cnt_d      = err_cnt_q;
    tick_pending_d = tick_pending_q;

    if (state_q == S_IDLE && state_d != S_IDLE) tick_pending_d = 1'b0;
    // A tick landing on the departure edge is kept so it is not lost.
    if (frame_tick) tick_pending_d = 1'b1;

    if (state_q == S_APPLY) begin
      case (dir)
        DIR_UP:      pos_y_d = y_dn;
        DIR_DOWN:    pos_y_d = y_up;
        DIR_LEFT:    pos_x_d = x_dn;
        DIR_RIGHT:   pos_x_d = x_up;
        DIR_ILLEGAL: if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        default:     ;
      endcase
    end

    // Clamping at a bound leaves the position unchanged, so no pulse then.
    move_pulse_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_pending_q <= 1'b0;
      pos_x_q        <= POS_W'(X_INIT);
      pos_y_q        <= POS_W'(Y_INIT);
      move_pulse_q   <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      tick_pending_q <= tick_pending_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      move_pulse_q   <= move_pulse_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign move_pulse = move_pulse_q;
  assign err_cnt    = err_cnt_q;

endmodule
